// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Memory-side responder for the GPU data-memory channel protocol. Per-channel
//   read/write requests are arbitrated round-robin onto one single-port
//   synchronous array. Each completed request gets a one-cycle ready pulse.
//   A host load port preloads the array and always wins the port.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   read_valid/_address : per-channel read request
//   read_ready/_data    : per-channel read completion pulse + word
//   write_valid/_address/_data : per-channel write request
//   write_ready         : per-channel write-commit pulse
//   load_valid/_address/_data  : host preload strobe (no handshake)
module data_memory_responder #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = 8,   // matches the GPU data-memory address width
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CHANNELS-1:0]                  read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  read_address,
    output logic [NUM_CHANNELS-1:0]                  read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  read_data,
    input  logic [NUM_CHANNELS-1:0]                  write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  write_data,
    output logic [NUM_CHANNELS-1:0]                  write_ready,
    input  logic                                     load_valid,
    input  logic [ADDR_WIDTH-1:0]                    load_address,
    input  logic [DATA_WIDTH-1:0]                    load_data
);
    localparam int RRW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [RRW-1:0]                         rr_q, rr_d;
    logic [NUM_CHANNELS-1:0]                read_ready_q, read_ready_d;
    logic [NUM_CHANNELS-1:0]                write_ready_q, write_ready_d;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0]                  rd_q;
    logic [DATA_WIDTH-1:0]                  mem [DEPTH];

    logic [NUM_CHANNELS-1:0] elig;
    logic                    gnt_vld, take, gnt_wr;
    logic [RRW-1:0]          gnt_idx;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_we;
    int                      c;

    // A channel whose ready pulse is showing still holds valid this cycle;
    // masking it prevents serving the same request twice.
    assign elig = (read_valid | write_valid) & ~(read_ready_q | write_ready_q);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            c = int'(rr_q) + i;
            if (c >= NUM_CHANNELS) c = c - NUM_CHANNELS;
            if (!gnt_vld && elig[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = RRW'(c);
            end
        end
    end

    // Load owns the port outright; a pending write beats a read on the same channel.
    assign take   = gnt_vld & ~load_valid;
    assign gnt_wr = write_valid[gnt_idx];

    always_comb begin
        mem_addr  = gnt_wr ? write_address[gnt_idx] : read_address[gnt_idx];
        mem_wdata = write_data[gnt_idx];
        if (load_valid) begin
            mem_addr  = load_address;
            mem_wdata = load_data;
        end
        // Nothing commits during reset, so memory survives a reset untouched.
        mem_we = ~reset & (load_valid | (take & gnt_wr));
    end

    always_comb begin
        rr_d          = rr_q;
        read_ready_d  = '0;
        write_ready_d = '0;
        if (take) begin
            rr_d = (gnt_idx == RRW'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + RRW'(1);
            if (gnt_wr) write_ready_d[gnt_idx] = 1'b1;
            else        read_ready_d[gnt_idx]  = 1'b1;
        end
    end

    // Single-port array, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_q <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q          <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            hold_q        <= '0;
        end else begin
            rr_q          <= rr_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            // Latch the shared RAM output so each channel keeps its last word.
            for (int k = 0; k < NUM_CHANNELS; k++)
                if (read_ready_q[k]) hold_q[k] <= rd_q;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_rdata
            assign read_data[g] = read_ready_q[g] ? rd_q : hold_q[g];
        end
    endgenerate

    assign read_ready  = read_ready_q;
    assign write_ready = write_ready_q;
endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;
    localparam int N  = 8;
    localparam int AW = 8;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          read_valid, read_ready, write_valid, write_ready;
    logic [N-1:0][AW-1:0]  read_address, write_address;
    logic [N-1:0][DW-1:0]  read_data, write_data;
    logic                  load_valid;
    logic [AW-1:0]         load_address;
    logic [DW-1:0]         load_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .read_valid(read_valid), .read_address(read_address),
        .read_ready(read_ready), .read_data(read_data),
        .write_valid(write_valid), .write_address(write_address),
        .write_data(write_data), .write_ready(write_ready),
        .load_valid(load_valid), .load_address(load_address), .load_data(load_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge: outputs are settled, inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_valid = 1'b1; load_address = a; load_data = d;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        read_valid = '0; write_valid = '0; read_address = '0;
        write_address = '0; write_data = '0;
        load_valid = 1'b0; load_address = '0; load_data = '0;
        #1;
        step(); step();
        chk("rst_rrdy", 32'(read_ready), 0);
        chk("rst_wrdy", 32'(write_ready), 0);
        chk("rst_rdata3", read_data[3], 0);
        chk("rst_rr", 32'(dut.rr_q), 0);
        reset = 1'b0;

        // Preload and single read on channel 3
        load(5, 32'hDEADBEEF);
        read_valid[3] = 1'b1; read_address[3] = 5;
        step();
        chk("t1_rrdy", 32'(read_ready), 32'h08);
        chk("t1_data", read_data[3], 32'hDEADBEEF);
        step();
        chk("t1_nodbl", 32'(read_ready), 0);
        chk("t1_hold", read_data[3], 32'hDEADBEEF);
        read_valid[3] = 1'b0;
        chk("t1_rr", 32'(dut.rr_q), 4);

        // Write then read-back on channel 0
        write_valid[0] = 1'b1; write_address[0] = 9; write_data[0] = 32'h12345678;
        step();
        chk("t2_wrdy", 32'(write_ready), 32'h01);
        chk("t2_rrdy0", 32'(read_ready), 0);
        step();
        write_valid[0] = 1'b0;
        read_valid[0] = 1'b1; read_address[0] = 9;
        step();
        chk("t2_rrdy", 32'(read_ready), 32'h01);
        chk("t2_data", read_data[0], 32'h12345678);
        step();
        read_valid[0] = 1'b0;

        // Preload 100+i, then reset to bring rr back to 0
        for (int i = 0; i < N; i++) load(AW'(i), 32'(100 + i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t3_rr0", 32'(dut.rr_q), 0);

        // All-channel contention
        for (int i = 0; i < N; i++) begin
            read_valid[i] = 1'b1; read_address[i] = AW'(i);
        end
        for (int k = 1; k <= N; k++) begin
            step();
            chk($sformatf("t3_rdy%0d", k - 1), 32'(read_ready), 32'(1) << (k - 1));
            chk($sformatf("t3_dat%0d", k - 1), read_data[k-1], 32'(100 + k - 1));
            if (k >= 2) read_valid[k-2] = 1'b0;
        end
        step();
        read_valid[N-1] = 1'b0;
        chk("t3_idle", 32'(read_ready), 0);
        chk("t3_wrap", 32'(dut.rr_q), 0);

        // Load priority over channels 2 and 6
        read_valid[2] = 1'b1; read_address[2] = 5;
        read_valid[6] = 1'b1; read_address[6] = 9;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1; load_address = AW'(20 + k); load_data = 32'(32'hA0 + k);
            step();
            chk($sformatf("t4_blk%0d", k), 32'(read_ready), 0);
            chk($sformatf("t4_rr%0d", k), 32'(dut.rr_q), 0);
        end
        load_valid = 1'b0;
        step();
        chk("t4_rdy2", 32'(read_ready), 32'h04);
        chk("t4_dat2", read_data[2], 105);
        step();
        read_valid[2] = 1'b0;
        chk("t4_rdy6", 32'(read_ready), 32'h40);
        chk("t4_dat6", read_data[6], 32'h12345678);
        step();
        read_valid[6] = 1'b0;
        chk("t4_rr", 32'(dut.rr_q), 7);

        // Simultaneous read and write on channel 1
        read_valid[1] = 1'b1; read_address[1] = 4;
        write_valid[1] = 1'b1; write_address[1] = 4; write_data[1] = 7;
        step();
        chk("t5_wrdy", 32'(write_ready), 32'h02);
        chk("t5_rrdy0", 32'(read_ready), 0);
        step();
        write_valid[1] = 1'b0;
        chk("t5_gap", 32'(read_ready | write_ready), 0);
        step();
        chk("t5_rrdy", 32'(read_ready), 32'h02);
        chk("t5_data", read_data[1], 7);
        step();
        read_valid[1] = 1'b0;

        // Reset during a channel 4 write grant
        load(2, 1);
        write_valid[4] = 1'b1; write_address[4] = 2; write_data[4] = 2;
        reset = 1'b1;
        step();
        reset = 1'b0; write_valid[4] = 1'b0;
        chk("t6_wrdy", 32'(write_ready), 0);
        chk("t6_rrdy", 32'(read_ready), 0);
        chk("t6_rdata1", read_data[1], 0);
        chk("t6_rr", 32'(dut.rr_q), 0);
        read_valid[4] = 1'b1; read_address[4] = 2;
        read_valid[5] = 1'b1; read_address[5] = 21;
        step();
        chk("t6_rrdy4", 32'(read_ready), 32'h10);
        chk("t6_old", read_data[4], 1);
        step();
        read_valid[4] = 1'b0;
        chk("t6_rrdy5", 32'(read_ready), 32'h20);
        chk("t6_load21", read_data[5], 32'hA1);
        step();
        read_valid[5] = 1'b0;
        chk("t6_end", 32'(read_ready | write_ready), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
